// File: rtl/xor_descrambler.sv
// xor_descrambler: self-synchronizing descrambler for 1 + x^6 + x^7.
// Each accepted beat is descrambled against a 7-bit history of prior line
// bits. The result goes out through a single registered output stage with a
// valid/ready handshake. out_lock marks beats whose every bit saw 7 real
// prior line bits.
module xor_descrambler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_lock
);

  // Lock FSM encoding
  localparam logic [0:0] FILL   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  // Time-ordered view: 7 history bits (oldest first) followed by the beat
  localparam int EXT_W = WIDTH + 7;

  logic [6:0]       hist_reg;
  logic [6:0]       hist_next;
  logic [2:0]       cnt_reg;
  logic [2:0]       cnt_next;
  logic [0:0]       state_reg;
  logic [0:0]       state_next;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic             out_lock_reg;
  logic             accept;
  logic [EXT_W-1:0] ext_stream;
  logic [WIDTH-1:0] desc_bits;
  logic [7:0]       cnt_sum;

  // The output register frees up when it is empty or being drained this cycle
  assign in_ready = !clr && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_lock  = out_lock_reg;

  // hist_reg[0] is the most recent bit, so it lands just below the new beat
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_hist_in
      assign ext_stream[gi] = hist_reg[6-gi];
    end
  endgenerate

  assign ext_stream[EXT_W-1:7] = in_data;

  // d[n] = s[n] ^ s[n-6] ^ s[n-7]; bit gi of the beat sits at ext index gi+7
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_desc
      assign desc_bits[gi] = ext_stream[gi+7] ^ ext_stream[gi+1] ^ ext_stream[gi];
    end
  endgenerate

  // The new history is the last 7 bits of the extended stream.
  // For narrow beats this is just a shift by WIDTH.
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_hist_out
      assign hist_next[gi] = ext_stream[WIDTH+6-gi];
    end
  endgenerate

  // Saturating fill counter and the FILL -> LOCKED transition
  always_comb begin
    cnt_sum    = {5'd0, cnt_reg} + 8'(WIDTH);
    cnt_next   = (cnt_sum >= 8'd7) ? 3'd7 : cnt_sum[2:0];
    state_next = state_reg;
    if (state_reg == FILL && cnt_next == 3'd7) begin
      state_next = LOCKED;
    end
  end

  // History, counter and lock state advance only on accepted beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_reg  <= '0;
      cnt_reg   <= '0;
      state_reg <= FILL;
    end else if (clr) begin
      hist_reg  <= '0;
      cnt_reg   <= '0;
      state_reg <= FILL;
    end else if (accept) begin
      hist_reg  <= hist_next;
      cnt_reg   <= cnt_next;
      state_reg <= state_next;
    end
  end

  // Output register: load on accept, empty on drain, hold under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_lock_reg  <= 1'b0;
    end else if (clr) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_lock_reg  <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= desc_bits;
      // Lock reflects history before this beat: LOCKED means 7 real bits
      out_lock_reg  <= (state_reg == LOCKED);
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xor_descrambler.sv
// Testbench for xor_descrambler. A WIDTH=8 instance is checked every cycle
// against a bit-stream reference model. A WIDTH=1 instance is checked
// against the expected lock-in sequence.
module tb_xor_descrambler;

  logic clk = 1'b0;
  logic rst_n;

  // WIDTH = 8 instance
  logic       clr8, in_valid8, in_ready8, out_valid8, out_ready8, out_lock8;
  logic [7:0] in_data8, out_data8;

  // WIDTH = 1 instance
  logic       clr1, in_valid1, in_ready1, out_valid1, out_ready1, out_lock1;
  logic [0:0] in_data1, out_data1;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state for the WIDTH = 8 instance
  bit         strm[$];   // every accepted scrambled bit since reset/clear
  logic       exp_valid;
  logic [7:0] exp_data;
  logic       exp_lock;
  logic       acc8;

  // Scrambler stream for the round-trip test
  bit         sc[$];

  xor_descrambler #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .clr(clr8),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_data(out_data8), .out_lock(out_lock8)
  );

  xor_descrambler #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .out_lock(out_lock1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scrambled bit at absolute stream index m; bits at or beyond base come from the beat
  function automatic bit sbit(input int m, input int base, input logic [7:0] s);
    if (m >= base) return s[m-base];
    if (m >= 0) return strm[m];
    return 1'b0;
  endfunction

  // d[n] = s[n] ^ s[n-6] ^ s[n-7], with bits before the stream start taken as 0
  function automatic logic [7:0] ref_desc(input logic [7:0] s);
    int base;
    logic [7:0] d;
    base = strm.size();
    for (int k = 0; k < 8; k++) begin
      d[k] = s[k] ^ sbit(base + k - 6, base, s) ^ sbit(base + k - 7, base, s);
    end
    return d;
  endfunction

  // Scrambler: s[n] = d[n] ^ s[n-6] ^ s[n-7]; does not commit the bits
  function automatic logic [7:0] scr_peek(input logic [7:0] plain);
    int base;
    int m;
    logic [7:0] s;
    bit t6;
    bit t7;
    base = sc.size();
    for (int k = 0; k < 8; k++) begin
      m = base + k - 6;
      t6 = (m >= base) ? s[m-base] : ((m >= 0) ? sc[m] : 1'b0);
      m = base + k - 7;
      t7 = (m >= base) ? s[m-base] : ((m >= 0) ? sc[m] : 1'b0);
      s[k] = plain[k] ^ t6 ^ t7;
    end
    return s;
  endfunction

  function automatic void model_reset();
    strm.delete();
    exp_valid = 1'b0;
    exp_data  = 8'h00;
    exp_lock  = 1'b0;
  endfunction

  // One clock cycle on dut8. Enter and leave 1 time unit after a rising edge.
  task automatic cycle8(input logic v, input logic [7:0] d, input logic ordy, input logic c);
    logic exp_ready;
    in_valid8  = v;
    in_data8   = d;
    out_ready8 = ordy;
    clr8       = c;
    #1;
    exp_ready = !c && (!exp_valid || ordy);
    acc8 = v && exp_ready;
    chk("in_ready", 64'(in_ready8), 64'(exp_ready));
    @(posedge clk);
    if (c) begin
      model_reset();
    end else if (acc8) begin
      exp_data  = ref_desc(d);
      exp_lock  = (strm.size() >= 7);
      exp_valid = 1'b1;
      for (int k = 0; k < 8; k++) strm.push_back(d[k]);
    end else if (ordy) begin
      exp_valid = 1'b0;
    end
    #1;
    chk("out_valid", 64'(out_valid8), 64'(exp_valid));
    chk("out_data", 64'(out_data8), 64'(exp_data));
    chk("out_lock", 64'(out_lock8), 64'(exp_lock));
    $display("beat v=%0b d=%02h ordy=%0b clr=%0b acc=%0b -> ov=%0b od=%02h ol=%0b",
             v, d, ordy, c, acc8, out_valid8, out_data8, out_lock8);
  endtask

  initial begin
    logic [7:0] bp_data[6];
    logic [7:0] held;
    logic [7:0] plain;
    logic [7:0] scr;
    logic       have;
    int         idx;
    int         acc_n;
    int         cyc;

    rst_n = 1'b0;
    {clr8, in_valid8, out_ready8, in_data8} = '0;
    {clr1, in_valid1, out_ready1, in_data1} = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    chk("rst_out_valid", 64'(out_valid8), 64'd0);
    chk("rst_out_data", 64'(out_data8), 64'd0);
    chk("rst_out_lock", 64'(out_lock8), 64'd0);
    chk("rst_in_ready", 64'(in_ready8), 64'd1);

    // WIDTH=1 lock-in: seven 1s give 1,1,1,1,1,1,0 unlocked, then 1 locked
    for (int i = 0; i < 8; i++) begin
      in_valid1  = 1'b1;
      in_data1   = 1'b1;
      out_ready1 = 1'b1;
      #1;
      chk("w1_in_ready", 64'(in_ready1), 64'd1);
      @(posedge clk);
      #1;
      chk("w1_valid", 64'(out_valid1), 64'd1);
      chk("w1_data", 64'(out_data1), (i == 6) ? 64'd0 : 64'd1);
      chk("w1_lock", 64'(out_lock1), (i == 7) ? 64'd1 : 64'd0);
      $display("w1 beat %0d -> od=%0b ol=%0b", i, out_data1, out_lock1);
    end
    in_valid1 = 1'b0;

    // Directed: 0xFF, 0xFF -> 0xBF unlocked, then 0xFF locked
    cycle8(1'b1, 8'hFF, 1'b1, 1'b0);
    chk("t1_data", 64'(out_data8), 64'hBF);
    chk("t1_lock", 64'(out_lock8), 64'd0);
    cycle8(1'b1, 8'hFF, 1'b1, 1'b0);
    chk("t2_data", 64'(out_data8), 64'hFF);
    chk("t2_lock", 64'(out_lock8), 64'd1);

    // Backpressure: drain first, then hold OUT_READY low for 5 cycles
    cycle8(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) bp_data[i] = 8'($urandom);
    idx = 0;
    held = 8'h00;
    for (int i = 0; i < 5; i++) begin
      cycle8(1'b1, bp_data[idx], 1'b0, 1'b0);
      if (i == 0) held = out_data8;
      else chk("bp_stable", 64'(out_data8), 64'(held));
      if (acc8) idx++;
    end
    chk("bp_accepted", 64'(idx), 64'd1);
    cyc = 0;
    while (idx < 6 && cyc < 20) begin
      cycle8(1'b1, bp_data[idx], 1'b1, 1'b0);
      if (acc8) idx++;
      cyc++;
    end
    chk("bp_resume", 64'(idx), 64'd6);

    // CLR with IN_VALID high: input rejected, output and lock cleared
    cycle8(1'b1, 8'h3C, 1'b1, 1'b0);
    cycle8(1'b1, 8'hAA, 1'b1, 1'b1);
    chk("clr_valid", 64'(out_valid8), 64'd0);
    chk("clr_lock", 64'(out_lock8), 64'd0);
    cycle8(1'b1, 8'hFF, 1'b1, 1'b0);
    chk("clr_ff_data", 64'(out_data8), 64'hBF);
    chk("clr_ff_lock", 64'(out_lock8), 64'd0);

    // Round trip: clear, then 1000 random beats through the scrambler model
    cycle8(1'b0, 8'h00, 1'b1, 1'b1);
    sc.delete();
    acc_n = 0;
    cyc   = 0;
    have  = 1'b0;
    plain = 8'h00;
    scr   = 8'h00;
    while (acc_n < 1000 && cyc < 5000) begin
      if (!have) begin
        plain = 8'($urandom);
        scr   = scr_peek(plain);
        have  = 1'b1;
      end
      cycle8($urandom_range(0, 3) != 0, scr, $urandom_range(0, 3) != 0, 1'b0);
      if (acc8) begin
        for (int k = 0; k < 8; k++) sc.push_back(scr[k]);
        acc_n++;
        if (acc_n == 1) chk("rt_first_lock", 64'(out_lock8), 64'd0);
        if (out_lock8) chk("rt_data", 64'(out_data8), 64'(plain));
        have = 1'b0;
      end
      cyc++;
    end
    chk("rt_beats", 64'(acc_n), 64'd1000);

    // Asynchronous reset between edges while OUT_VALID=1
    cycle8(1'b0, 8'h00, 1'b1, 1'b0);
    cycle8(1'b1, 8'h5A, 1'b0, 1'b0);
    chk("ar_pre_valid", 64'(out_valid8), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("ar_valid", 64'(out_valid8), 64'd0);
    chk("ar_data", 64'(out_data8), 64'd0);
    chk("ar_lock", 64'(out_lock8), 64'd0);
    chk("ar_w1_valid", 64'(out_valid1), 64'd0);
    chk("ar_w1_lock", 64'(out_lock1), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle8(1'b1, 8'hFF, 1'b1, 1'b0);
    chk("ar_ff_data", 64'(out_data8), 64'hBF);
    chk("ar_ff_lock", 64'(out_lock8), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
